// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor: pixel colour,
// game-state encoding and winner codes.
package sprite_pkg;

    localparam int unsigned CH_W  = 8;
    localparam int unsigned SUM_W = 10;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        PLAY     = 2'd0,
        PENDING  = 2'd1,
        GAMEOVER = 2'd2
    } gs_state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

endpackage

// File: rtl/sprite_tint_sat.sv
// Damage tint: brightens each channel by damage*TINT_STEP, saturating at 255.
module sprite_tint_sat
    import sprite_pkg::*;
#(
    parameter int unsigned TINT_STEP = 50
) (
    input  rgb_t       color,
    input  logic [1:0] damage,
    output rgb_t       tinted
);

    logic [SUM_W-1:0] inc;

    assign inc = SUM_W'(damage) * SUM_W'(TINT_STEP);

    // Wide add so an overflow clamps instead of wrapping.
    function automatic logic [CH_W-1:0] sat_add(input logic [CH_W-1:0] ch,
                                                input logic [SUM_W-1:0] add);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(ch) + add;
        return (sum > SUM_W'(255)) ? CH_W'(255) : sum[CH_W-1:0];
    endfunction

    assign tinted.r = sat_add(color.r, inc);
    assign tinted.g = sat_add(color.g, inc);
    assign tinted.b = sat_add(color.b, inc);

endmodule

// File: rtl/sprite_compositor.sv
// Layered sprite compositor with colour key, damage tint and the
// play/game-over state machine; output aligned to the sprite ROM latency.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_LAYERS  = 8,
    parameter int unsigned COORD_W     = 10,
    parameter int unsigned ADDR_W      = 19,
    parameter int unsigned ROM_LATENCY = 1,
    parameter logic [23:0] BG_COLOR    = 24'hB7FE7B,
    parameter logic [23:0] KEY_COLOR   = 24'hFF0000,
    parameter int unsigned TINT_STEP   = 50,
    parameter logic [NUM_LAYERS-1:0] OVERLAY_MASK = NUM_LAYERS'(8'b1100_0000)
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            frame_start,
    input  logic                            pixel_valid,
    input  logic [COORD_W-1:0]              DrawX,
    input  logic [COORD_W-1:0]              DrawY,
    input  logic [NUM_LAYERS-1:0]           layer_hit,
    input  logic [NUM_LAYERS*COORD_W-1:0]   layer_origin_x,
    input  logic [NUM_LAYERS*COORD_W-1:0]   layer_origin_y,
    input  logic [NUM_LAYERS*4-1:0]         layer_shift,
    input  logic [NUM_LAYERS*2-1:0]         layer_damage,
    input  logic [1:0]                      player_dead,
    input  logic                            restart,
    output logic [NUM_LAYERS*ADDR_W-1:0]    rom_addr,
    input  logic [NUM_LAYERS*24-1:0]        rom_data,
    output logic [7:0]                      VGA_R,
    output logic [7:0]                      VGA_G,
    output logic [7:0]                      VGA_B,
    output logic                            out_valid,
    output logic                            game_over,
    output logic [1:0]                      winner
);

    typedef struct packed {
        logic                      valid;
        logic                      mode;
        logic [NUM_LAYERS-1:0]     hit;
        logic [NUM_LAYERS*2-1:0]   damage;
    } side_t;

    gs_state_t state, state_next;
    logic [1:0] winner_q, winner_next;
    logic       pend_q, pend_next;
    logic       game_over_q;

    side_t side0, side_d;
    side_t side_pipe [ROM_LATENCY];

    rgb_t                  tinted [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] opaque;
    rgb_t                  pixel_next, pixel_q;
    logic                  valid_q;

    // Stage 0: per-layer ROM address and opacity/tint per layer.
    for (genvar g = 0; g < int'(NUM_LAYERS); g++) begin : g_layer
        logic [ADDR_W-1:0] dx, dy;

        assign dx = ADDR_W'(DrawX) - ADDR_W'(layer_origin_x[g*COORD_W +: COORD_W]);
        assign dy = ADDR_W'(DrawY) - ADDR_W'(layer_origin_y[g*COORD_W +: COORD_W]);
        assign rom_addr[g*ADDR_W +: ADDR_W] =
            layer_hit[g] ? (dx + (dy << layer_shift[g*4 +: 4])) : '0;

        sprite_tint_sat #(
            .TINT_STEP(TINT_STEP)
        ) u_tint (
            .color (rgb_t'(rom_data[g*24 +: 24])),
            .damage(side_d.damage[g*2 +: 2]),
            .tinted(tinted[g])
        );

        assign opaque[g] = side_d.hit[g]
                         && (rom_data[g*24 +: 24] != KEY_COLOR)
                         && (side_d.damage[g*2 +: 2] != 2'd3)
                         && (!side_d.mode || OVERLAY_MASK[g]);
    end

    assign side0 = {pixel_valid, (state == GAMEOVER), layer_hit, layer_damage};

    // Side-band delay line matching the sprite ROM read latency.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < int'(ROM_LATENCY); i++) begin
                side_pipe[i] <= '0;
            end
        end else begin
            side_pipe[0] <= side0;
            for (int i = 1; i < int'(ROM_LATENCY); i++) begin
                side_pipe[i] <= side_pipe[i-1];
            end
        end
    end

    assign side_d = side_pipe[ROM_LATENCY-1];

    // Priority mux: scanning upward-to-downward leaves the lowest opaque index.
    always_comb begin
        pixel_next = side_d.mode ? rgb_t'(24'h000000) : rgb_t'(BG_COLOR);
        for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                pixel_next = tinted[i];
            end
        end
        if (!side_d.valid) begin
            pixel_next = '0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pixel_q <= '0;
            valid_q <= 1'b0;
        end else begin
            pixel_q <= pixel_next;
            valid_q <= side_d.valid;
        end
    end

    assign VGA_R     = pixel_q.r;
    assign VGA_G     = pixel_q.g;
    assign VGA_B     = pixel_q.b;
    assign out_valid = valid_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= PLAY;
            winner_q    <= WIN_NONE;
            pend_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state       <= state_next;
            winner_q    <= winner_next;
            pend_q      <= pend_next;
            game_over_q <= (state_next == GAMEOVER);
        end
    end

    // Mode changes only on frame_start; a restart is remembered only in GAMEOVER.
    always_comb begin
        state_next  = state;
        winner_next = winner_q;
        pend_next   = pend_q;
        unique case (state)
            PLAY: begin
                pend_next = 1'b0;
                if (player_dead != 2'b00) begin
                    state_next = PENDING;
                    unique case (player_dead)
                        2'b10:   winner_next = WIN_P1;
                        2'b01:   winner_next = WIN_P2;
                        default: winner_next = WIN_DRAW;
                    endcase
                end
            end
            PENDING: begin
                pend_next = 1'b0;
                if (frame_start) begin
                    state_next = GAMEOVER;
                end
            end
            GAMEOVER: begin
                if (frame_start && (restart || pend_q)) begin
                    state_next  = PLAY;
                    winner_next = WIN_NONE;
                    pend_next   = 1'b0;
                end else if (restart) begin
                    pend_next = 1'b1;
                end
            end
            default: state_next = PLAY;
        endcase
    end

    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed scenarios plus randomized pixels
// checked against an arithmetic reference model of compositing and game state.
module tb_sprite_compositor;

    localparam int NL = 8;
    localparam int CW = 10;
    localparam int AW = 19;
    localparam int STEP = 50;
    localparam logic [23:0] BG  = 24'hB7FE7B;
    localparam logic [23:0] KEY = 24'hFF0000;
    localparam logic [7:0]  OVL = 8'b1100_0000;

    logic           Clk;
    logic           Reset;
    logic           frame_start;
    logic           pixel_valid;
    logic [CW-1:0]  DrawX, DrawY;
    logic [NL-1:0]  layer_hit;
    logic [NL*CW-1:0] layer_origin_x, layer_origin_y;
    logic [NL*4-1:0]  layer_shift;
    logic [NL*2-1:0]  layer_damage;
    logic [1:0]     player_dead;
    logic           restart;
    logic [NL*AW-1:0] rom_addr;
    logic [NL*24-1:0] rom_data;
    logic [7:0]     VGA_R, VGA_G, VGA_B;
    logic           out_valid;
    logic           game_over;
    logic [1:0]     winner;

    logic [NL-1:0]  force_en;
    logic [23:0]    force_val [NL];

    int compared;
    int mismatched;

    int ms;          // 0 play, 1 pending, 2 game over
    int mwin;
    bit mpend;
    logic [24:0] q [$];

    sprite_compositor dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pixel_valid(pixel_valid),
        .DrawX(DrawX), .DrawY(DrawY), .layer_hit(layer_hit),
        .layer_origin_x(layer_origin_x), .layer_origin_y(layer_origin_y),
        .layer_shift(layer_shift), .layer_damage(layer_damage),
        .player_dead(player_dead), .restart(restart), .rom_addr(rom_addr),
        .rom_data(rom_data), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .out_valid(out_valid), .game_over(game_over), .winner(winner)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [23:0] rom_content(input int i, input logic [AW-1:0] a);
        logic [31:0] h;
        if (force_en[i]) return force_val[i];
        h = (32'(a) * 32'h9E3779B1) ^ (32'(i) * 32'h85EBCA77);
        h = h ^ (h >> 15);
        if (h[4:0] == 5'd0) return KEY;
        return h[23:0];
    endfunction

    // External single-cycle synchronous sprite ROMs.
    always @(posedge Clk) begin
        for (int i = 0; i < NL; i++) begin
            rom_data[i*24 +: 24] <= rom_content(i, rom_addr[i*AW +: AW]);
        end
    end

    function automatic logic [AW-1:0] exp_addr(input int i);
        int dx, dy;
        if (!layer_hit[i]) return '0;
        dx = int'(DrawX) - int'(layer_origin_x[i*CW +: CW]);
        dy = int'(DrawY) - int'(layer_origin_y[i*CW +: CW]);
        return AW'(dx + dy * (1 << int'(layer_shift[i*4 +: 4])));
    endfunction

    function automatic int tint_ch(input int ch, input int dmg);
        int v;
        v = ch + dmg * STEP;
        return (v > 255) ? 255 : v;
    endfunction

    function automatic logic [24:0] model_px();
        logic [23:0] c;
        logic [23:0] d;
        int dmg;
        bit go;
        bit found;
        go = (ms == 2);
        if (!pixel_valid) return '0;
        c = go ? 24'h000000 : BG;
        found = 0;
        for (int i = 0; i < NL; i++) begin
            if (!found && layer_hit[i]) begin
                d = rom_content(i, exp_addr(i));
                dmg = int'(layer_damage[i*2 +: 2]);
                if (d != KEY && dmg < 3 && (!go || OVL[i])) begin
                    c = {8'(tint_ch(int'(d[23:16]), dmg)), 8'(tint_ch(int'(d[15:8]), dmg)),
                         8'(tint_ch(int'(d[7:0]), dmg))};
                    found = 1;
                end
            end
        end
        return {1'b1, c};
    endfunction

    task automatic model_step();
        case (ms)
            0: if (player_dead != 2'b00) begin
                ms = 1;
                mwin = (player_dead == 2'b11) ? 3 : ((player_dead == 2'b10) ? 1 : 2);
            end
            1: if (frame_start) ms = 2;
            default: begin
                if (frame_start && (restart || mpend)) begin
                    ms = 0; mwin = 0; mpend = 0;
                end else if (restart) begin
                    mpend = 1;
                end
            end
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] out_pix();
        return {out_valid, VGA_R, VGA_G, VGA_B};
    endfunction

    // One clock: address check, queue the expected pixel, advance, compare.
    task automatic cycle();
        #1;
        for (int i = 0; i < NL; i++) begin
            check($sformatf("rom_addr%0d", i), 32'(rom_addr[i*AW +: AW]), 32'(exp_addr(i)));
        end
        q.push_back(model_px());
        model_step();
        @(posedge Clk);
        #1;
        if (q.size() >= 2) begin
            check("pixel", 32'(out_pix()), 32'(q[0]));
            void'(q.pop_front());
        end
        check("game_over", 32'(game_over), 32'(ms == 2));
        check("winner", 32'(winner), 32'(mwin));
    endtask

    task automatic clear_layers();
        layer_hit = '0;
        layer_damage = '0;
        force_en = '0;
    endtask

    task automatic set_layer(input int i, input int ox, input int oy, input int sh,
                             input int dmg, input logic [23:0] col);
        layer_hit[i] = 1'b1;
        layer_origin_x[i*CW +: CW] = CW'(ox);
        layer_origin_y[i*CW +: CW] = CW'(oy);
        layer_shift[i*4 +: 4] = 4'(sh);
        layer_damage[i*2 +: 2] = 2'(dmg);
        force_en[i] = 1'b1;
        force_val[i] = col;
    endtask

    task automatic rand_pixel(input int hit_pct);
        pixel_valid = ($urandom_range(0, 7) != 0);
        DrawX = CW'($urandom_range(0, 639));
        DrawY = CW'($urandom_range(0, 479));
        force_en = '0;
        for (int i = 0; i < NL; i++) begin
            layer_hit[i] = ($urandom_range(0, 99) < hit_pct);
            layer_origin_x[i*CW +: CW] = CW'($urandom_range(0, 1023));
            layer_origin_y[i*CW +: CW] = CW'($urandom_range(0, 1023));
            layer_shift[i*4 +: 4] = 4'($urandom_range(0, 15));
            layer_damage[i*2 +: 2] = 2'($urandom_range(0, 3));
        end
    endtask

    initial begin
        compared = 0; mismatched = 0;
        ms = 0; mwin = 0; mpend = 0;
        Reset = 1'b1; frame_start = 0; pixel_valid = 0; restart = 0; player_dead = 0;
        DrawX = 0; DrawY = 0; layer_origin_x = '0; layer_origin_y = '0; layer_shift = '0;
        clear_layers();
        for (int i = 0; i < NL; i++) force_val[i] = '0;

        repeat (3) @(posedge Clk);
        #1;
        check("reset_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h0);
        check("reset_valid", 32'(out_valid), 32'h0);
        check("reset_game_over", 32'(game_over), 32'h0);
        check("reset_winner", 32'(winner), 32'h0);
        Reset = 1'b0;
        q.push_back('0);

        // Address example and two-cycle latency.
        pixel_valid = 1; DrawX = 103; DrawY = 52;
        set_layer(0, 100, 50, 5, 0, 24'h123456);
        #1;
        check("addr_67", 32'(rom_addr[AW-1:0]), 32'd67);
        cycle();
        clear_layers(); pixel_valid = 0;
        cycle();
        check("latency_px", 32'(out_pix()), {7'd0, 1'b1, 24'h123456});

        // Colour key falls through to a lower-priority layer; then background.
        pixel_valid = 1; DrawX = 300; DrawY = 200;
        set_layer(0, 290, 190, 4, 0, KEY);
        set_layer(3, 280, 180, 6, 0, 24'h00FF00);
        cycle();
        clear_layers();
        cycle();
        check("key_px", 32'(out_pix()), {7'd0, 1'b1, 24'h00FF00});
        pixel_valid = 0;
        cycle();
        check("bg_px", 32'(out_pix()), {7'd0, 1'b1, BG});

        // Tint and saturation; damage 3 hides the layer.
        pixel_valid = 1;
        set_layer(2, 10, 10, 3, 1, 24'hE01080);
        cycle();
        layer_damage[5:4] = 2'd2;
        cycle();
        check("tint1", 32'(out_pix()), {7'd0, 1'b1, 24'hFF42B2});
        layer_damage[5:4] = 2'd3;
        cycle();
        check("tint2", 32'(out_pix()), {7'd0, 1'b1, 24'hFF74E4});
        clear_layers(); pixel_valid = 0;
        cycle();
        check("dmg3_bg", 32'(out_pix()), {7'd0, 1'b1, BG});

        for (int n = 0; n < 300; n++) begin
            rand_pixel(40);
            frame_start = (n % 50 == 0);
            restart = ($urandom_range(0, 19) == 0);
            cycle();
        end
        frame_start = 0; restart = 0; clear_layers();

        // Game over entry is frame aligned.
        pixel_valid = 1; DrawX = 5; DrawY = 5;
        frame_start = 1; cycle(); frame_start = 0;
        cycle();
        player_dead = 2'b10;
        for (int n = 0; n < 5; n++) begin
            set_layer(3, 0, 0, 2, 0, 24'h445566);
            cycle();
            check("pending_go", 32'(game_over), 32'h0);
        end
        check("winner_p1", 32'(winner), 32'h1);
        frame_start = 1; cycle(); frame_start = 0;
        check("go_entry", 32'(game_over), 32'h1);
        player_dead = 2'b00;
        cycle();
        cycle();
        check("go_suppress", 32'(out_pix()), {7'd0, 1'b1, 24'h000000});
        clear_layers();
        set_layer(7, 0, 0, 2, 0, 24'h0A0B0C);
        cycle();
        clear_layers();
        cycle();
        check("go_overlay", 32'(out_pix()), {7'd0, 1'b1, 24'h0A0B0C});

        // Remembered restart acts on the next frame_start.
        restart = 1; cycle(); restart = 0;
        for (int n = 0; n < 100; n++) begin
            rand_pixel(40);
            cycle();
        end
        frame_start = 1; cycle(); frame_start = 0;
        check("restart_go", 32'(game_over), 32'h0);
        check("restart_win", 32'(winner), 32'h0);

        // Draw, then restart coincident with frame_start.
        player_dead = 2'b11; cycle(); player_dead = 2'b00;
        check("winner_draw", 32'(winner), 32'h3);
        frame_start = 1; cycle(); frame_start = 0;
        check("draw_go", 32'(game_over), 32'h1);
        frame_start = 1; restart = 1; cycle(); frame_start = 0; restart = 0;
        check("coinc_go", 32'(game_over), 32'h0);
        check("coinc_win", 32'(winner), 32'h0);

        for (int n = 0; n < 1500; n++) begin
            rand_pixel(35);
            frame_start = (n % 37 == 0);
            restart = ($urandom_range(0, 29) == 0);
            player_dead = ($urandom_range(0, 59) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cycle();
        end
        restart = 0; player_dead = 0;

        // Reset while in GAMEOVER with pixels in flight.
        frame_start = 1; cycle(); frame_start = 0;
        player_dead = 2'b01; cycle(); player_dead = 2'b00;
        frame_start = 1; cycle(); frame_start = 0;
        check("pre_reset_go", 32'(game_over), 32'h1);
        rand_pixel(50); pixel_valid = 1; cycle();
        rand_pixel(50); pixel_valid = 1; cycle();
        Reset = 1'b1;
        #1;
        check("arst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h0);
        check("arst_valid", 32'(out_valid), 32'h0);
        check("arst_go", 32'(game_over), 32'h0);
        check("arst_win", 32'(winner), 32'h0);
        ms = 0; mwin = 0; mpend = 0;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        q.delete();
        q.push_back('0);
        clear_layers(); pixel_valid = 1;
        cycle();
        check("rel_first", 32'(out_valid), 32'h0);
        pixel_valid = 0;
        cycle();
        check("rel_second", 32'(out_pix()), {7'd0, 1'b1, BG});
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
